// File: rtl/cpf_frame_sequencer.sv
// cpf_frame_sequencer
//
// Upstream stage of the CP_F frame encoder. Accepts one frame request
// (status, control, address, 16-bit data) on a valid/ready handshake and
// emits it one byte per clock:
//   SOF(K) status control address data_h data_l CRC-slot EOF(K)
// Idle commas fill the line between frames. The CRC itself and the 8b/10b
// coding are done downstream; this block only flags the CRC slot and
// frames the CRC window with crc_reset.
//
// Ports
//   clk           single clock
//   reset         asynchronous, active-low reset
//   req_valid     frame request present
//   req_ready     request accepted this cycle (combinational)
//   status_in     status byte
//   control_in    control byte
//   address_in    address byte
//   data_word_in  16-bit data, MSB byte sent first
//   data_out        byte to encoder                  (registered)
//   is_control_byte data_out is a K character        (registered)
//   is_crc_byte     encoder substitutes running CRC  (registered)
//   crc_reset       hold CRC generator at init value (registered)
//   busy            frame in progress, SOF..EOF      (registered)
//   frame_done      one-cycle pulse during EOF byte  (registered)
//
// Configuration
//   CPF_SEQ_IDLE_GAP_EN  when defined, enforces at least IDLE_GAP idle
//                        cycles between EOF and the next SOF; requests are
//                        then accepted only in IDLE. When undefined,
//                        requests are also accepted during EOF so frames
//                        can run back-to-back.

module cpf_frame_sequencer #(
  parameter logic [7:0] K_IDLE = 8'hBC,
  parameter logic [7:0] K_SOF  = 8'hFB,
  parameter logic [7:0] K_EOF  = 8'hFD
`ifdef CPF_SEQ_IDLE_GAP_EN
  , parameter int unsigned IDLE_GAP = 2
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  status_in,
  input  logic [7:0]  control_in,
  input  logic [7:0]  address_in,
  input  logic [15:0] data_word_in,
  output logic [7:0]  data_out,
  output logic        is_control_byte,
  output logic        is_crc_byte,
  output logic        crc_reset,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_STATUS,
    ST_CONTROL,
    ST_ADDR,
    ST_DATA_H,
    ST_DATA_L,
    ST_CRC,
    ST_EOF
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  control_q, control_d;
  logic [7:0]  address_q, address_d;
  logic [15:0] data_word_q, data_word_d;

  logic [7:0]  data_out_q, data_out_d;
  logic        is_control_byte_q, is_control_byte_d;
  logic        is_crc_byte_q, is_crc_byte_d;
  logic        crc_reset_q, crc_reset_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  logic        accept;

`ifdef CPF_SEQ_IDLE_GAP_EN
  localparam logic [3:0] GapMax  = 4'(IDLE_GAP);
  localparam logic [4:0] GapNeed = 5'(IDLE_GAP);

  logic [3:0] gap_q, gap_d;
  logic [4:0] gap_elapsed;

  // gap_q counts completed IDLE cycles since EOF; the current IDLE cycle
  // also counts as elapsed, so a request can be taken on the edge that
  // ends the IDLE_GAP-th idle cycle (exactly IDLE_GAP commas on the line).
  assign gap_elapsed = {1'b0, gap_q} + 5'd1;
  assign req_ready   = (state_q == ST_IDLE) && (gap_elapsed >= GapNeed);

  always_comb begin
    gap_d = gap_q;
    if (state_q == ST_EOF) begin
      gap_d = 4'd0;
    end else if ((state_q == ST_IDLE) && (gap_q != GapMax)) begin
      gap_d = gap_q + 4'd1;
    end
  end

  // Resets to IDLE_GAP so the first request after reset is taken at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gap_q <= GapMax;
    else        gap_q <= gap_d;
  end
`else
  // EOF also accepts, letting the next SOF follow EOF with no idle byte.
  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_EOF);
`endif

  assign accept = req_valid && req_ready;

  // Next state, field capture, and next-cycle outputs. Outputs are derived
  // from state_d so they are registered yet aligned with the state.
  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    control_d   = control_q;
    address_d   = address_q;
    data_word_d = data_word_q;

    if (accept) begin
      status_d    = status_in;
      control_d   = control_in;
      address_d   = address_in;
      data_word_d = data_word_in;
    end

    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_SOF;
      ST_SOF:     state_d = ST_STATUS;
      ST_STATUS:  state_d = ST_CONTROL;
      ST_CONTROL: state_d = ST_ADDR;
      ST_ADDR:    state_d = ST_DATA_H;
      ST_DATA_H:  state_d = ST_DATA_L;
      ST_DATA_L:  state_d = ST_CRC;
      ST_CRC:     state_d = ST_EOF;
      ST_EOF:     state_d = accept ? ST_SOF : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    data_out_d        = K_IDLE;
    is_control_byte_d = 1'b1;
    is_crc_byte_d     = 1'b0;
    crc_reset_d       = 1'b1;
    busy_d            = (state_d != ST_IDLE);
    frame_done_d      = (state_d == ST_EOF);

    case (state_d)
      ST_SOF: data_out_d = K_SOF;
      ST_STATUS, ST_CONTROL, ST_ADDR, ST_DATA_H, ST_DATA_L: begin
        is_control_byte_d = 1'b0;
        crc_reset_d       = 1'b0;
        case (state_d)
          ST_STATUS:  data_out_d = status_q;
          ST_CONTROL: data_out_d = control_q;
          ST_ADDR:    data_out_d = address_q;
          ST_DATA_H:  data_out_d = data_word_q[15:8];
          default:    data_out_d = data_word_q[7:0];
        endcase
      end
      // crc_reset rises with the slot: the generator clears on the same
      // edge the encoder captures the CRC it has accumulated.
      ST_CRC: begin
        data_out_d        = 8'h00;
        is_control_byte_d = 1'b0;
        is_crc_byte_d     = 1'b1;
      end
      ST_EOF:  data_out_d = K_EOF;
      default: data_out_d = K_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      status_q          <= 8'h00;
      control_q         <= 8'h00;
      address_q         <= 8'h00;
      data_word_q       <= 16'h0000;
      data_out_q        <= K_IDLE;
      is_control_byte_q <= 1'b1;
      is_crc_byte_q     <= 1'b0;
      crc_reset_q       <= 1'b1;
      busy_q            <= 1'b0;
      frame_done_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      status_q          <= status_d;
      control_q         <= control_d;
      address_q         <= address_d;
      data_word_q       <= data_word_d;
      data_out_q        <= data_out_d;
      is_control_byte_q <= is_control_byte_d;
      is_crc_byte_q     <= is_crc_byte_d;
      crc_reset_q       <= crc_reset_d;
      busy_q            <= busy_d;
      frame_done_q      <= frame_done_d;
    end
  end

  assign data_out        = data_out_q;
  assign is_control_byte = is_control_byte_q;
  assign is_crc_byte     = is_crc_byte_q;
  assign crc_reset       = crc_reset_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_cpf_frame_sequencer.sv
// Directed testbench for cpf_frame_sequencer. Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Built with or without
// CPF_SEQ_IDLE_GAP_EN; the gap build uses IDLE_GAP = 3.

module tb_cpf_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  status_in;
  logic [7:0]  control_in;
  logic [7:0]  address_in;
  logic [15:0] data_word_in;
  logic [7:0]  data_out;
  logic        is_control_byte;
  logic        is_crc_byte;
  logic        crc_reset;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

`ifdef CPF_SEQ_IDLE_GAP_EN
  localparam logic EofReady = 1'b0;
  cpf_frame_sequencer #(.IDLE_GAP(3)) dut (
`else
  localparam logic EofReady = 1'b1;
  cpf_frame_sequencer dut (
`endif
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .status_in       (status_in),
    .control_in      (control_in),
    .address_in      (address_in),
    .data_word_in    (data_word_in),
    .data_out        (data_out),
    .is_control_byte (is_control_byte),
    .is_crc_byte     (is_crc_byte),
    .crc_reset       (crc_reset),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [7:0] s, input logic [7:0] c,
                           input logic [7:0] a, input logic [15:0] d);
    req_valid    = 1'b1;
    status_in    = s;
    control_in   = c;
    address_in   = a;
    data_word_in = d;
  endtask

  // Idle-line outputs; req_ready checked only when it must be 1.
  task automatic check_idle(input string tag, input bit chk_ready);
    check({tag, " data"}, data_out, 8'hBC);
    check({tag, " ctl"}, is_control_byte, 1'b1);
    check({tag, " crcflag"}, is_crc_byte, 1'b0);
    check({tag, " crc_reset"}, crc_reset, 1'b1);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " done"}, frame_done, 1'b0);
    if (chk_ready) check({tag, " ready"}, req_ready, 1'b1);
  endtask

  task automatic idle_cycles(input string tag, input int n, input bit chk_ready);
    for (int i = 0; i < n; i++) begin
      tick();
      check_idle($sformatf("%s idle%0d", tag, i), chk_ready);
    end
  endtask

  // Called in the SOF cycle; returns in the EOF cycle without ticking past
  // it. pulse_at >= 0 raises req_valid with junk fields for that one cycle.
  task automatic expect_frame(input string name, input logic [7:0] s,
                              input logic [7:0] c, input logic [7:0] a,
                              input logic [15:0] d, input int pulse_at);
    logic [7:0] exp_b [8];
    exp_b = '{8'hFB, s, c, a, d[15:8], d[7:0], 8'h00, 8'hFD};
    for (int k = 0; k < 8; k++) begin
      if (pulse_at >= 0 && k == pulse_at) begin
        drive_req(8'hAA, 8'h55, 8'hCC, 16'h3333);
      end else if (pulse_at >= 0 && k == pulse_at + 1) begin
        req_valid = 1'b0;
      end
      check($sformatf("%s k%0d data", name, k), data_out, exp_b[k]);
      check($sformatf("%s k%0d ctl", name, k), is_control_byte, (k == 0 || k == 7));
      check($sformatf("%s k%0d crcflag", name, k), is_crc_byte, (k == 6));
      check($sformatf("%s k%0d crc_reset", name, k), crc_reset, !(k >= 1 && k <= 5));
      check($sformatf("%s k%0d busy", name, k), busy, 1'b1);
      check($sformatf("%s k%0d done", name, k), frame_done, (k == 7));
      check($sformatf("%s k%0d ready", name, k), req_ready, (k == 7) ? EofReady : 1'b0);
      if (k < 7) tick();
    end
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    status_in    = 8'h00;
    control_in   = 8'h00;
    address_in   = 8'h00;
    data_word_in = 16'h0000;

    // Reset state held for a few cycles.
    tick();
    tick();
    check_idle("rst", 1'b1);
    @(negedge clk);
    reset = 1'b1;
    idle_cycles("post_rst", 10, 1'b1);

    // Single frame.
    drive_req(8'h5A, 8'h01, 8'h20, 16'hBEEF);
    check("single ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    expect_frame("single", 8'h5A, 8'h01, 8'h20, 16'hBEEF, -1);
    idle_cycles("single_after", 3, 1'b0);

    // req_valid pulsed mid-frame is ignored and the frame is unchanged.
    drive_req(8'h12, 8'h34, 8'h56, 16'h789A);
    tick();
    req_valid = 1'b0;
    expect_frame("pulse", 8'h12, 8'h34, 8'h56, 16'h789A, 3);
    idle_cycles("pulse_after", 3, 1'b0);

    // req_valid held high with two requests.
    drive_req(8'hA1, 8'hA2, 8'hA3, 16'hA4A5);
    tick();
    drive_req(8'hB1, 8'hB2, 8'hB3, 16'hB4B5);
    expect_frame("b2b_a", 8'hA1, 8'hA2, 8'hA3, 16'hA4A5, -1);
`ifdef CPF_SEQ_IDLE_GAP_EN
    tick();
    check_idle("gap1", 1'b0);
    check("gap1 ready", req_ready, 1'b0);
    tick();
    check_idle("gap2", 1'b0);
    check("gap2 ready", req_ready, 1'b0);
    tick();
    check_idle("gap3", 1'b1);
`endif
    tick();
    drive_req(8'hEE, 8'hEE, 8'hEE, 16'hEEEE);
    req_valid = 1'b0;
    expect_frame("b2b_b", 8'hB1, 8'hB2, 8'hB3, 16'hB4B5, -1);
    idle_cycles("b2b_after", 3, 1'b0);

    // Asynchronous reset during DATA_H abandons the frame immediately.
    drive_req(8'hC1, 8'hC2, 8'hC3, 16'hC4C5);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    check("rst_mid data_h", data_out, 8'hC4);
    #2;
    reset = 1'b0;
    #1;
    check_idle("rst_mid", 1'b1);
    tick();
    check_idle("rst_mid hold", 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    tick();
    check_idle("rst_rel", 1'b1);

    drive_req(8'hD1, 8'hD2, 8'hD3, 16'hD4D5);
    tick();
    req_valid = 1'b0;
    expect_frame("after_rst", 8'hD1, 8'hD2, 8'hD3, 16'hD4D5, -1);
    idle_cycles("final", 4, 1'b0);
    check_idle("final_ready", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
